// File: rtl/sn76489_write_decoder.sv
// SN76489 host write port: latch/data byte decoder driving the attenuation, tone and noise registers.
// Optional READY busy handshake is built only when SN76489_READY_EN is defined.
module sn76489_write_decoder #(
  parameter int NUM_TONES                = 3,
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int FREQUENCY_COUNTER_BITS   = 10,
  parameter int NOISE_CONTROL_BITS       = 3,
  parameter int READY_CYCLES             = 32
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [7:0]                                     data,
  input  logic                                           we,
  output logic                                           ready,
  output logic [(NUM_TONES+1)*ATTENUATION_CONTROL_BITS-1:0] attn,
  output logic [NUM_TONES*FREQUENCY_COUNTER_BITS-1:0]    tone_freq,
  output logic [NOISE_CONTROL_BITS-1:0]                  noise_ctrl,
  output logic                                           noise_reset
);

  localparam int NUM_CH = NUM_TONES + 1;
  localparam int ACB    = ATTENUATION_CONTROL_BITS;
  localparam int FCB    = FREQUENCY_COUNTER_BITS;
  localparam int NCB    = NOISE_CONTROL_BITS;

  if (FREQUENCY_COUNTER_BITS != 10) begin : g_bad_freq_bits
    $error("FREQUENCY_COUNTER_BITS must be 10");
  end
  if (READY_CYCLES < 1) begin : g_bad_ready_cycles
    $error("READY_CYCLES must be at least 1");
  end

  logic [ACB-1:0] attn_q [NUM_CH];
  logic [ACB-1:0] attn_d [NUM_CH];
  logic [FCB-1:0] tone_q [NUM_TONES];
  logic [FCB-1:0] tone_d [NUM_TONES];
  logic [NCB-1:0] noise_q, noise_d;
  logic [1:0]     latch_ch_q, latch_ch_d;
  logic           latch_type_q, latch_type_d;
  logic           noise_reset_q, noise_reset_d;
  logic           ready_int;
  logic           accept;
  logic [1:0]     tgt_ch;
  logic           tgt_type;

`ifdef SN76489_READY_EN
  localparam int CW = $clog2(READY_CYCLES + 1);
  logic [CW-1:0] busy_q, busy_d;

  // Acceptance only happens at count zero, so load and decrement never collide.
  always_comb begin
    busy_d = busy_q;
    if (accept) begin
      busy_d = CW'(READY_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign ready_int = (busy_q == '0);
`else
  assign ready_int = 1'b1;
`endif

  always_comb begin
    accept   = we & ready_int & ~reset;
    // Data bytes reuse the last latched channel/type; latch bytes carry their own.
    tgt_ch   = data[7] ? data[6:5] : latch_ch_q;
    tgt_type = data[7] ? data[4]   : latch_type_q;

    for (int i = 0; i < NUM_CH; i++) begin
      attn_d[i] = attn_q[i];
    end
    for (int i = 0; i < NUM_TONES; i++) begin
      tone_d[i] = tone_q[i];
    end
    noise_d       = noise_q;
    latch_ch_d    = latch_ch_q;
    latch_type_d  = latch_type_q;
    noise_reset_d = 1'b0;

    if (accept) begin
      if (data[7]) begin
        latch_ch_d   = data[6:5];
        latch_type_d = data[4];
      end
      if (tgt_type) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (2'(i) == tgt_ch) begin
            attn_d[i] = data[ACB-1:0];
          end
        end
      end else if (tgt_ch == 2'(NUM_TONES)) begin
        noise_d       = data[NCB-1:0];
        noise_reset_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_TONES; i++) begin
          if (2'(i) == tgt_ch) begin
            tone_d[i] = data[7] ? {tone_q[i][9:4], data[3:0]}
                                : {data[5:0], tone_q[i][3:0]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        attn_q[i] <= '1;
      end
      for (int i = 0; i < NUM_TONES; i++) begin
        tone_q[i] <= '0;
      end
      noise_q       <= '0;
      latch_ch_q    <= 2'd0;
      latch_type_q  <= 1'b0;
      noise_reset_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        attn_q[i] <= attn_d[i];
      end
      for (int i = 0; i < NUM_TONES; i++) begin
        tone_q[i] <= tone_d[i];
      end
      noise_q       <= noise_d;
      latch_ch_q    <= latch_ch_d;
      latch_type_q  <= latch_type_d;
      noise_reset_q <= noise_reset_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_attn_out
    assign attn[gi*ACB +: ACB] = attn_q[gi];
  end
  for (genvar gi = 0; gi < NUM_TONES; gi++) begin : g_tone_out
    assign tone_freq[gi*FCB +: FCB] = tone_q[gi];
  end

  assign noise_ctrl  = noise_q;
  assign noise_reset = noise_reset_q;
  assign ready       = ready_int;

endmodule

// File: doc/sn76489_write_decoder.md
# sn76489_write_decoder

Host-side write port of the SN76489 PSG: accepts the chip's native byte-wide latch/data write protocol and maintains the control registers that the tone, noise and attenuation channels consume (4 attenuation, 3 tone frequency, 1 noise control). It sits directly upstream of the PSG core and replaces the core's hard-wired reset-time register values. It also generates the one-cycle noise-LFSR restart pulse and the chip's READY busy handshake.

## Interface
Parameters:
- NUM_TONES, 3, number of tone channels; the noise channel is index NUM_TONES (latch channel code 3)
- ATTENUATION_CONTROL_BITS, 4, width of each attenuation register
- FREQUENCY_COUNTER_BITS, 10, width of each tone register; must equal 10 (4 latch bits + 6 data bits)
- NOISE_CONTROL_BITS, 3, width of the noise control register
- READY_CYCLES, 32, busy cycles after each accepted write; must be ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data  in  8  write byte
- we  in  1  write request, sampled every clk edge
- ready  out  1  high = next write will be accepted
- attn  out  4*ATTENUATION_CONTROL_BITS  channel i at [i*4 +: 4]; 0 = loudest, 0xF = silent
- tone_freq  out  NUM_TONES*FREQUENCY_COUNTER_BITS  tone i at [i*10 +: 10]
- noise_ctrl  out  NOISE_CONTROL_BITS  {fb, nf1, nf0}
- noise_reset  out  1  one-cycle pulse on every noise-register write

## Operation
- Accept: write accepted on any edge where we=1, ready=1 and reset=0. All other we cycles are ignored; no queuing.
- Latch byte (data[7]=1): data[6:5] = channel c, data[4] = type t (1 = attenuation, 0 = tone/noise), data[3:0] = value.
  - Stores {c,t} into the internal latch register, then applies the value:
  - t=1: attn[c] <= data[3:0].
  - t=0, c<3: tone_freq[c][3:0] <= data[3:0]; bits [9:4] unchanged.
  - t=0, c=3: noise_ctrl <= data[2:0]; noise_reset pulses.
- Data byte (data[7]=0): target is the last latched {c,t}.
  - Tone: tone_freq[c][9:4] <= data[5:0]; bits [3:0] unchanged.
  - Attenuation: attn[c] <= data[3:0].
  - Noise: noise_ctrl <= data[2:0]; noise_reset pulses.
  - data[6] ignored.
- Busy counter: loaded with READY_CYCLES on acceptance, decremented each cycle; ready = (count == 0).
- Reset values:
  - attn = all 0xF
  - tone_freq = 0
  - noise_ctrl = 0
  - latch {c,t} = {0,0} (tone 0)
  - noise_reset = 0
  - ready = 1
  - busy count = 0
- Reset mid-busy: the count clears; ready is 1 in the first cycle after reset.
- Reset is ignored only by nothing: the accept condition includes reset=0, so a write requested while reset is high is dropped.

## Timing
- A write accepted at edge N: the register update, latch update and noise_reset=1 are all visible after edge N and hold for exactly one cycle (noise_reset) or until the next write (registers).
- ready falls after edge N, stays low for READY_CYCLES cycles, and is high again after edge N+READY_CYCLES.
- Back-to-back: the earliest next acceptance is edge N+READY_CYCLES.
- A we held high continuously produces one accepted write per READY_CYCLES cycles.
- No combinational path from data/we to any output.

## Configuration
- SN76489_READY_EN defined: busy counter and READY behaviour exactly as above.
- SN76489_READY_EN undefined:
  - No counter is built; ready is tied to 1.
  - Every cycle with we=1 and reset=0 is accepted, allowing one write per cycle.
  - Register timing is otherwise identical.

## Test plan
- After reset: attn=0xFFFF, tone_freq=0, noise_ctrl=0, ready=1, noise_reset=0.
- Write 0x8E then, once ready=1, 0x0F: tone_freq[0] = 0x0FE; ready low for exactly 32 cycles after each write.
- Write 0xD5: attn[2]=0x5. Then write 0x03: attn[2]=0x3, and tone_freq is unchanged.
- Write 0xE6: noise_ctrl=3'b110 with a single-cycle noise_reset. Then write 0x01: noise_ctrl=3'b001 with another single-cycle pulse.
- Pulse we during busy (with SN76489_READY_EN defined): the write is ignored and no register changes. Assert reset at busy cycle 10: ready=1 and all registers return to reset values.
- Without SN76489_READY_EN: writes 0xA7 and 0x12 on consecutive cycles give tone_freq[1] = 0x127 two cycles later; ready stays 1 throughout.
